// File: rtl/command_word_sequencer.sv
// 8259A command-word sequencer: decodes CPU writes into one-cycle ICW/OCW
// strobes, tracks the ICW1..ICW4 initialization sequence, flags rejected writes.
module command_word_sequencer #(
  parameter logic ALLOW_OCW_IN_INIT = 1'b0,
  parameter logic RESET_TO_READY    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_enable,
  input  logic       address_a0,
  input  logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic [7:0] command_data,
  output logic       init_busy,
  output logic       end_of_initialization,
  output logic       sequence_error
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  // Strobe vector bit positions.
  localparam int S_ICW1 = 0;
  localparam int S_ICW2 = 1;
  localparam int S_ICW3 = 2;
  localparam int S_ICW4 = 3;
  localparam int S_OCW1 = 4;
  localparam int S_OCW2 = 5;
  localparam int S_OCW3 = 6;

  state_t     state_reg, state_next;
  logic       sngl_reg, sngl_next;
  logic       ic4_reg, ic4_next;
  logic [6:0] strobe_reg, strobe_next;
  logic [7:0] command_data_reg, command_data_next;
  logic       init_busy_reg, init_busy_next;
  logic       eoi_reg, eoi_next;
  logic       error_reg, error_next;

  logic in_wait;
  logic ocw_allowed;

  assign in_wait     = (state_reg == WAIT_ICW2) || (state_reg == WAIT_ICW3) ||
                       (state_reg == WAIT_ICW4);
  assign ocw_allowed = (state_reg == READY) || (ALLOW_OCW_IN_INIT && in_wait);

  always_comb begin
    state_next        = state_reg;
    sngl_next         = sngl_reg;
    ic4_next          = ic4_reg;
    strobe_next       = 7'd0;
    eoi_next          = 1'b0;
    error_next        = 1'b0;
    command_data_next = command_data_reg;

    if (write_enable) begin
      if (!address_a0) begin
        if (internal_data_bus[4]) begin
          // ICW1 always restarts the sequence, even mid-initialization.
          strobe_next[S_ICW1] = 1'b1;
          sngl_next           = internal_data_bus[1];
          ic4_next            = internal_data_bus[0];
          state_next          = WAIT_ICW2;
        end else if (ocw_allowed) begin
          if (internal_data_bus[3]) strobe_next[S_OCW3] = 1'b1;
          else                      strobe_next[S_OCW2] = 1'b1;
        end else begin
          error_next = 1'b1;
        end
      end else begin
        case (state_reg)
          WAIT_ICW2: begin
            strobe_next[S_ICW2] = 1'b1;
            if (!sngl_reg)    state_next = WAIT_ICW3;
            else if (ic4_reg) state_next = WAIT_ICW4;
            else              state_next = READY;
          end
          WAIT_ICW3: begin
            strobe_next[S_ICW3] = 1'b1;
            state_next          = ic4_reg ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            strobe_next[S_ICW4] = 1'b1;
            state_next          = READY;
          end
          READY:   strobe_next[S_OCW1] = 1'b1;
          default: error_next          = 1'b1;
        endcase
      end

      if (|strobe_next) command_data_next = internal_data_bus;
      // Only a write leaving a WAIT_* state for READY ends initialization.
      if (in_wait && state_next == READY) eoi_next = 1'b1;
    end

    init_busy_next = (state_next == WAIT_ICW2) || (state_next == WAIT_ICW3) ||
                     (state_next == WAIT_ICW4);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= RESET_TO_READY ? READY : UNINIT;
      sngl_reg         <= 1'b0;
      ic4_reg          <= 1'b0;
      strobe_reg       <= 7'd0;
      command_data_reg <= 8'h00;
      init_busy_reg    <= 1'b0;
      eoi_reg          <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sngl_reg         <= sngl_next;
      ic4_reg          <= ic4_next;
      strobe_reg       <= strobe_next;
      command_data_reg <= command_data_next;
      init_busy_reg    <= init_busy_next;
      eoi_reg          <= eoi_next;
      error_reg        <= error_next;
    end
  end

  assign write_initial_command_word_1   = strobe_reg[S_ICW1];
  assign write_initial_command_word_2   = strobe_reg[S_ICW2];
  assign write_initial_command_word_3   = strobe_reg[S_ICW3];
  assign write_initial_command_word_4   = strobe_reg[S_ICW4];
  assign write_operation_control_word_1 = strobe_reg[S_OCW1];
  assign write_operation_control_word_2 = strobe_reg[S_OCW2];
  assign write_operation_control_word_3 = strobe_reg[S_OCW3];
  assign command_data                   = command_data_reg;
  assign init_busy                      = init_busy_reg;
  assign end_of_initialization          = eoi_reg;
  assign sequence_error                 = error_reg;

endmodule
